// File: rtl/memoria_dato_resp.sv
// Multi-cycle data memory for the MIPS memory stage: answers each read or
// write after WAIT_CYCLES wait states with a one-cycle Ready strobe.
module memoria_dato_resp #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] MemRes,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] memRes_q;
  logic        ready_q;
  logic        addrErr_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          request;
  logic          enterResp;
  logic [31:0]   accAddr;
  logic [31:0]   accData;
  logic          accWrite;
  logic          accIllegal;
  logic [AW-1:0] accIdx;

  assign request = MemRead | MemWrite;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the array is accessed on the capture edge itself,
  // so the access must see the live inputs rather than the captured copy.
  always_comb begin
    accAddr  = addr_q;
    accData  = wdata_q;
    accWrite = write_q;
    if (state_q == IDLE) begin
      accAddr  = Address;
      accData  = WriteData;
      accWrite = MemWrite;
    end
    accIllegal = (accAddr[1:0] != 2'b00) ||
                 ({2'b00, accAddr[31:2]} >= 32'(DEPTH_WORDS));
    accIdx     = accAddr[AW+1:2];
    enterResp  = (state_d == RESP) && (state_q != RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      memRes_q  <= '0;
      ready_q   <= 1'b0;
      addrErr_q <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= enterResp;
      addrErr_q <= enterResp && accIllegal;
      if (state_q == IDLE && request) begin
        addr_q  <= Address;
        wdata_q <= WriteData;
        write_q <= MemWrite;
      end
      if (enterResp) begin
        if (accIllegal) begin
          memRes_q <= '0;
        end else if (accWrite) begin
          mem_q[accIdx] <= accData;
        end else begin
          memRes_q <= mem_q[accIdx];
        end
      end
    end
  end

  assign MemRes  = memRes_q;
  assign Ready   = ready_q;
  assign AddrErr = addrErr_q;
  assign Busy    = (state_q != IDLE);

endmodule
